// File: rtl/bp_be_late_wb_arbiter_pkg.sv
// Shared back-end types for the late-writeback arbiter: source encoding and fflags width.
package bp_be_pkg;

    localparam int fflags_width_gp = 5;

    // Encodes both the current grant and the round-robin pointer.
    typedef enum logic {
        e_late_src_int = 1'b0,
        e_late_src_fp  = 1'b1
    } bp_be_late_wb_src_e;

endpackage

// File: rtl/bp_be_late_wb_arbiter_if.sv
// Bundle of the two long-pipe writeback streams and the shared late-writeback port.
// master = long pipe / register-file side, slave = the arbiter.
interface bp_be_late_wb_arbiter_if
    import bp_be_pkg::*;
#(
    parameter int reg_addr_width_p = 5,
    parameter int idata_width_p    = 64,
    parameter int fdata_width_p    = 66
);

    logic                        iwb_v_i;
    logic [reg_addr_width_p-1:0] iwb_rd_addr_i;
    logic [idata_width_p-1:0]    iwb_data_i;
    logic                        iwb_yumi_o;

    logic                        fwb_v_i;
    logic [reg_addr_width_p-1:0] fwb_rd_addr_i;
    logic [fdata_width_p-1:0]    fwb_data_i;
    logic [fflags_width_gp-1:0]  fwb_fflags_i;
    logic                        fwb_yumi_o;

    logic                        late_v_o;
    logic                        late_ready_and_i;
    logic                        late_ird_w_v_o;
    logic                        late_frd_w_v_o;
    logic [reg_addr_width_p-1:0] late_rd_addr_o;
    logic [fdata_width_p-1:0]    late_rd_data_o;
    logic                        late_fflags_w_v_o;
    logic [fflags_width_gp-1:0]  late_fflags_o;
    logic                        busy_o;

    modport master (
        output iwb_v_i, iwb_rd_addr_i, iwb_data_i,
        output fwb_v_i, fwb_rd_addr_i, fwb_data_i, fwb_fflags_i,
        output late_ready_and_i,
        input  iwb_yumi_o, fwb_yumi_o,
        input  late_v_o, late_ird_w_v_o, late_frd_w_v_o, late_rd_addr_o,
        input  late_rd_data_o, late_fflags_w_v_o, late_fflags_o, busy_o
    );

    modport slave (
        input  iwb_v_i, iwb_rd_addr_i, iwb_data_i,
        input  fwb_v_i, fwb_rd_addr_i, fwb_data_i, fwb_fflags_i,
        input  late_ready_and_i,
        output iwb_yumi_o, fwb_yumi_o,
        output late_v_o, late_ird_w_v_o, late_frd_w_v_o, late_rd_addr_o,
        output late_rd_data_o, late_fflags_w_v_o, late_fflags_o, busy_o
    );

endinterface

// File: rtl/bp_be_late_wb_slot.sv
// One-entry holding slot; accepts a new entry whenever empty or draining this cycle.
module bp_be_late_wb_slot #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               yumi_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               drain_i
);

    logic               full;
    logic [width_p-1:0] data_r;

    // Gated by reset so no source is released while the core is held in reset.
    assign yumi_o = v_i & reset_n_i & (~full | drain_i);
    assign v_o    = full;
    assign data_o = data_r;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            full   <= 1'b0;
            data_r <= '0;
        end else if (yumi_o) begin
            full   <= 1'b1;
            data_r <= data_i;
        end else if (drain_i) begin
            full   <= 1'b0;
        end
    end

endmodule

// File: rtl/bp_be_late_wb_arbiter.sv
// Merges integer div/rem and FP div/sqrt late writebacks onto one register-file port.
// BP_BE_LATE_WB_RR_EN selects round-robin; otherwise integer has fixed priority over FP.
module bp_be_late_wb_arbiter
    import bp_be_pkg::*;
#(
    parameter int reg_addr_width_p = 5,
    parameter int idata_width_p    = 64,
    parameter int fdata_width_p    = 66
) (
    input logic                    clk_i,
    input logic                    reset_n_i,
    bp_be_late_wb_arbiter_if.slave wb
);

    localparam int ipay_w = reg_addr_width_p + idata_width_p;
    localparam int fpay_w = reg_addr_width_p + fdata_width_p + fflags_width_gp;

    logic              int_full, fp_full, int_drain, fp_drain;
    logic [ipay_w-1:0] int_pay;
    logic [fpay_w-1:0] fp_pay;
    logic              late_v, grant_int, grant_fp;
    logic              hold_v;
    bp_be_late_wb_src_e arb_src, grant, hold_src;

    bp_be_late_wb_slot #(.width_p(ipay_w)) int_slot (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (wb.iwb_v_i),
        .data_i   ({wb.iwb_rd_addr_i, wb.iwb_data_i}),
        .yumi_o   (wb.iwb_yumi_o),
        .v_o      (int_full),
        .data_o   (int_pay),
        .drain_i  (int_drain)
    );

    bp_be_late_wb_slot #(.width_p(fpay_w)) fp_slot (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .v_i      (wb.fwb_v_i),
        .data_i   ({wb.fwb_rd_addr_i, wb.fwb_data_i, wb.fwb_fflags_i}),
        .yumi_o   (wb.fwb_yumi_o),
        .v_o      (fp_full),
        .data_o   (fp_pay),
        .drain_i  (fp_drain)
    );

`ifdef BP_BE_LATE_WB_RR_EN
    bp_be_late_wb_src_e last_fp;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            last_fp <= e_late_src_int;
        else if (int_drain | fp_drain)
            last_fp <= grant;
    end
`endif

    always_comb begin
        arb_src = e_late_src_int;
        if (int_full & fp_full) begin
`ifdef BP_BE_LATE_WB_RR_EN
            arb_src = (last_fp == e_late_src_int) ? e_late_src_fp : e_late_src_int;
`else
            arb_src = e_late_src_int;
`endif
        end else if (fp_full) begin
            arb_src = e_late_src_fp;
        end
    end

    // A stalled grant is frozen so a slot filling mid-stall cannot swap the payload.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            hold_v   <= 1'b0;
            hold_src <= e_late_src_int;
        end else begin
            hold_v   <= late_v & ~wb.late_ready_and_i;
            hold_src <= grant;
        end
    end

    assign grant     = hold_v ? hold_src : arb_src;
    assign late_v    = int_full | fp_full;
    assign grant_int = late_v & (grant == e_late_src_int);
    assign grant_fp  = late_v & (grant == e_late_src_fp);
    assign int_drain = grant_int & wb.late_ready_and_i;
    assign fp_drain  = grant_fp & wb.late_ready_and_i;

    logic [reg_addr_width_p-1:0] rd_addr;
    logic [fdata_width_p-1:0]    rd_data;
    logic [fflags_width_gp-1:0]  fflags;

    always_comb begin
        rd_addr = '0;
        rd_data = '0;
        fflags  = '0;
        if (grant_fp) begin
            {rd_addr, rd_data, fflags} = fp_pay;
        end else if (grant_int) begin
            rd_addr = int_pay[ipay_w-1 -: reg_addr_width_p];
            rd_data = fdata_width_p'(int_pay[idata_width_p-1:0]);
        end
    end

    assign wb.late_v_o          = late_v;
    assign wb.late_ird_w_v_o    = grant_int;
    assign wb.late_frd_w_v_o    = grant_fp;
    assign wb.late_fflags_w_v_o = grant_fp;
    assign wb.late_rd_addr_o    = rd_addr;
    assign wb.late_rd_data_o    = rd_data;
    assign wb.late_fflags_o     = fflags;
    assign wb.busy_o            = late_v;

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// Directed-vector bench for bp_be_late_wb_arbiter; expected values are hand-computed.
module tb_bp_be_late_wb_arbiter;
    import bp_be_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    bp_be_late_wb_arbiter_if #(.reg_addr_width_p(5), .idata_width_p(64), .fdata_width_p(66)) wb();

    bp_be_late_wb_arbiter #(.reg_addr_width_p(5), .idata_width_p(64), .fdata_width_p(66)) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .wb       (wb)
    );

    localparam logic [65:0] F1 = 66'h3_0123_4567_89AB_CDEF;
    localparam logic [65:0] F2 = 66'h1_FEDC_BA98_7654_3210;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic ird, input logic frd,
                           input logic [4:0] addr, input logic [65:0] data, input logic [4:0] fl);
        chk({tag, ".v"},     128'(wb.late_v_o),          128'(v));
        chk({tag, ".ird"},   128'(wb.late_ird_w_v_o),    128'(ird));
        chk({tag, ".frd"},   128'(wb.late_frd_w_v_o),    128'(frd));
        chk({tag, ".flw"},   128'(wb.late_fflags_w_v_o), 128'(frd));
        chk({tag, ".addr"},  128'(wb.late_rd_addr_o),    128'(addr));
        chk({tag, ".data"},  128'(wb.late_rd_data_o),    128'(data));
        chk({tag, ".fl"},    128'(wb.late_fflags_o),     128'(fl));
        chk({tag, ".busy"},  128'(wb.busy_o),            128'(v));
    endtask

    task automatic set_i(input logic v, input logic [4:0] a, input logic [63:0] d);
        wb.iwb_v_i = v; wb.iwb_rd_addr_i = a; wb.iwb_data_i = d;
    endtask

    task automatic set_f(input logic v, input logic [4:0] a, input logic [65:0] d, input logic [4:0] fl);
        wb.fwb_v_i = v; wb.fwb_rd_addr_i = a; wb.fwb_data_i = d; wb.fwb_fflags_i = fl;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_i(1'b1, 5'd7, 64'hDEAD_BEEF);
        set_f(1'b0, 5'd0, 66'd0, 5'd0);
        wb.late_ready_and_i = 1'b1;

        // reset held with a valid integer source present
        @(negedge clk);
        chk_out("rst", 0, 0, 0, 5'd0, 66'd0, 5'd0);
        chk("rst.iyumi", 128'(wb.iwb_yumi_o), 128'(0));
        chk("rst.fyumi", 128'(wb.fwb_yumi_o), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("rel.iyumi", 128'(wb.iwb_yumi_o), 128'(1));
        next_cyc();
        set_i(1'b0, 5'd0, 64'd0);
        @(negedge clk);
        chk_out("int", 1, 1, 0, 5'd7, 66'hDEAD_BEEF, 5'd0);
        next_cyc();
        @(negedge clk);
        chk_out("int_done", 0, 0, 0, 5'd0, 66'd0, 5'd0);
        next_cyc();

        // FP result under backpressure, second FP result waiting behind it
        wb.late_ready_and_i = 1'b0;
        set_f(1'b1, 5'd3, F1, 5'b00001);
        @(negedge clk);
        chk("bp.fyumi0", 128'(wb.fwb_yumi_o), 128'(1));
        next_cyc();
        set_f(1'b1, 5'd4, F2, 5'b00100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_out("bp", 1, 0, 1, 5'd3, F1, 5'b00001);
            chk("bp.fyumi", 128'(wb.fwb_yumi_o), 128'(0));
            next_cyc();
        end
        wb.late_ready_and_i = 1'b1;
        @(negedge clk);
        chk("bp_rel.fyumi", 128'(wb.fwb_yumi_o), 128'(1));
        chk_out("bp_rel", 1, 0, 1, 5'd3, F1, 5'b00001);
        next_cyc();
        set_f(1'b0, 5'd0, 66'd0, 5'd0);
        @(negedge clk);
        chk_out("bp2", 1, 0, 1, 5'd4, F2, 5'b00100);
        next_cyc();
        @(negedge clk);
        chk("bp_done.v", 128'(wb.late_v_o), 128'(0));
        next_cyc();

        // back-to-back integer refill, ready high
        set_i(1'b1, 5'd10, 64'd1);
        @(negedge clk);
        chk("b2b0.iyumi", 128'(wb.iwb_yumi_o), 128'(1));
        chk("b2b0.v", 128'(wb.late_v_o), 128'(0));
        next_cyc();
        set_i(1'b1, 5'd11, 64'd2);
        @(negedge clk);
        chk("b2b1.iyumi", 128'(wb.iwb_yumi_o), 128'(1));
        chk_out("b2b1", 1, 1, 0, 5'd10, 66'd1, 5'd0);
        next_cyc();
        set_i(1'b1, 5'd12, 64'd3);
        @(negedge clk);
        chk("b2b2.iyumi", 128'(wb.iwb_yumi_o), 128'(1));
        chk_out("b2b2", 1, 1, 0, 5'd11, 66'd2, 5'd0);
        next_cyc();
        set_i(1'b0, 5'd0, 64'd0);
        @(negedge clk);
        chk_out("b2b3", 1, 1, 0, 5'd12, 66'd3, 5'd0);
        next_cyc();
        @(negedge clk);
        chk("b2b_done.v", 128'(wb.late_v_o), 128'(0));
        next_cyc();

        // stalled FP grant must not be stolen by an integer result arriving mid-stall
        wb.late_ready_and_i = 1'b0;
        set_f(1'b1, 5'd5, F1, 5'b10000);
        @(negedge clk);
        next_cyc();
        set_f(1'b0, 5'd0, 66'd0, 5'd0);
        set_i(1'b1, 5'd6, 64'h55);
        @(negedge clk);
        chk("lock.iyumi", 128'(wb.iwb_yumi_o), 128'(1));
        next_cyc();
        set_i(1'b0, 5'd0, 64'd0);
        @(negedge clk);
        chk_out("lock", 1, 0, 1, 5'd5, F1, 5'b10000);
        next_cyc();
        wb.late_ready_and_i = 1'b1;
        @(negedge clk);
        chk_out("lock_rel", 1, 0, 1, 5'd5, F1, 5'b10000);
        next_cyc();
        @(negedge clk);
        chk_out("lock_int", 1, 1, 0, 5'd6, 66'h55, 5'd0);
        next_cyc();
        @(negedge clk);
        chk("lock_done.v", 128'(wb.late_v_o), 128'(0));
        next_cyc();

`ifdef BP_BE_LATE_WB_RR_EN
        // collision: pointer last saw integer, so FP first; then pointer alternates
        set_i(1'b1, 5'd1, 64'hA1);
        set_f(1'b1, 5'd2, F1, 5'b00010);
        @(negedge clk);
        chk("rr0.iyumi", 128'(wb.iwb_yumi_o), 128'(1));
        chk("rr0.fyumi", 128'(wb.fwb_yumi_o), 128'(1));
        next_cyc();
        set_i(1'b0, 5'd0, 64'd0);
        set_f(1'b1, 5'd8, F2, 5'b01000);
        @(negedge clk);
        chk_out("rr1", 1, 0, 1, 5'd2, F1, 5'b00010);
        chk("rr1.fyumi", 128'(wb.fwb_yumi_o), 128'(1));
        next_cyc();
        set_f(1'b0, 5'd0, 66'd0, 5'd0);
        @(negedge clk);
        chk_out("rr2", 1, 1, 0, 5'd1, 66'hA1, 5'd0);
        next_cyc();
        @(negedge clk);
        chk_out("rr3", 1, 0, 1, 5'd8, F2, 5'b01000);
        next_cyc();
        @(negedge clk);
        chk("rr_done.v", 128'(wb.late_v_o), 128'(0));
        next_cyc();
`else
        // fixed priority: integer keeps winning while its stream continues
        set_i(1'b1, 5'd1, 64'hA1);
        set_f(1'b1, 5'd2, F1, 5'b00010);
        @(negedge clk);
        chk("fp0.iyumi", 128'(wb.iwb_yumi_o), 128'(1));
        chk("fp0.fyumi", 128'(wb.fwb_yumi_o), 128'(1));
        next_cyc();
        set_i(1'b1, 5'd9, 64'hB2);
        set_f(1'b0, 5'd0, 66'd0, 5'd0);
        @(negedge clk);
        chk_out("fp1", 1, 1, 0, 5'd1, 66'hA1, 5'd0);
        chk("fp1.iyumi", 128'(wb.iwb_yumi_o), 128'(1));
        next_cyc();
        set_i(1'b1, 5'd13, 64'hC3);
        @(negedge clk);
        chk_out("fp2", 1, 1, 0, 5'd9, 66'hB2, 5'd0);
        next_cyc();
        set_i(1'b0, 5'd0, 64'd0);
        @(negedge clk);
        chk_out("fp3", 1, 1, 0, 5'd13, 66'hC3, 5'd0);
        next_cyc();
        @(negedge clk);
        chk_out("fp4", 1, 0, 1, 5'd2, F1, 5'b00010);
        next_cyc();
        @(negedge clk);
        chk("fp_done.v", 128'(wb.late_v_o), 128'(0));
        next_cyc();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
